busca_instrucao: RTL



---
 rtl/busca_instrucao.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage of the 8-bit multicycle processor.
// Owns the PC and the instruction register, runs the request/valid
// handshake with instruction memory, splits the fetched byte into the
// fields used by the control unit and computes the next PC.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one-cycle gap after reset; memory responses are discarded
// REQ   | ImemReq high, ImemAddr = PC, waiting for ImemValid
// EXEC  | IR holds the instruction; control unit decodes it this cycle
// HALT  | processor stopped; only reset leaves this state
module busca_instrucao #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  // instruction memory
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemValid,
  input  logic [7:0]        ImemData,
  // control unit / datapath
  input  logic              PCWrite,
  input  logic              Jump,
  input  logic              Cond,
  input  logic [1:0]        JumpValue,
  input  logic              Zero,
  input  logic [ADDR_W-1:0] JumpReg,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Stall,
  // decoded instruction and status
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus1,
  output logic [1:0]        Opcode,
  output logic [2:0]        Funct,
  output logic [1:0]        RegA,
  output logic [1:0]        RegB,
  output logic [4:0]        Imm,
  output logic              InstrValid,
  output logic              Halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] imm_ext;
  logic [7:0]        ir;

  // strobes produced by the FSM for the datapath registers
  logic              capture;
  logic              advance;
  logic              taken;

  // State register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and register update strobes
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        // ImemValid deliberately ignored: flushes any stale response
        state_next = REQ;
      end
      REQ: begin
        if (ImemValid) begin
          capture    = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // halt outranks stall so a stalled halt instruction still stops
        if (!PCWrite) begin
          state_next = HALT;
        end else if (!Stall) begin
          advance    = 1'b1;
          state_next = REQ;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Program counter: loaded only when an instruction retires
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= pc_next;
    end
  end

  // Instruction register: captured on an accepted memory response
  always_ff @(posedge clock) begin
    if (reset) begin
      ir <= 8'h00;
    end else if (capture) begin
      ir <= ImemData;
    end
  end

  assign pc_plus1 = pc + ADDR_W'(1);
  assign imm_ext  = ADDR_W'(ir[5:1]);

  // Taken is gated by Jump first so an undriven Cond/JumpValue on a
  // non-jump instruction cannot disturb the sequential PC
  assign taken = Jump & (~Cond | Zero);

  // Next-PC selection
  always_comb begin
    pc_next = pc_plus1;
    if (taken) begin
      case (JumpValue)
        2'b00:   pc_next = imm_ext;
        2'b01:   pc_next = JumpReg;
        2'b10:   pc_next = BranchTarget;
        default: pc_next = pc_plus1;
      endcase
    end
  end

  assign ImemReq    = (state == REQ);
  assign ImemAddr   = pc;
  assign InstrValid = (state == EXEC);
  assign Halted     = (state == HALT);

  assign PC         = pc;
  assign PCPlus1    = pc_plus1;

  assign Opcode     = ir[7:6];
  assign RegA       = ir[5:4];
  assign RegB       = ir[3:2];
  assign Funct      = ir[2:0];
  assign Imm        = ir[5:1];

endmodule
